// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract sequencer driving an external
// 1-bit full adder, LSB first, one bit per clock. Subtraction is A + ~B + 1.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_sub;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             w_accept;
  logic             w_last;

  assign w_accept = (r_state == IDLE) && start;
  assign w_last   = (r_state == RUN) && (r_cnt == LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode and full-adder / status outputs.
  always_comb begin
    w_next = r_state;
    fa_a   = 1'b0;
    fa_b   = 1'b0;
    fa_cin = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next = RUN;
      end
      RUN: begin
        busy   = 1'b1;
        fa_a   = r_a[0];
        fa_b   = r_b[0] ^ r_sub;
        fa_cin = r_carry;
        if (r_cnt == LAST) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Datapath: operand latch, serial shift, carry chain, result capture.
  // Operands shift right so bit i is always at position 0 in RUN cycle i;
  // result bits enter at the MSB and reach their own position after WIDTH shifts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sub   <= 1'b0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_cnt   <= '0;
      r_a     <= op_a;
      r_b     <= op_b;
      r_sub   <= sub;
      r_carry <= sub ? 1'b1 : carry_in;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (r_state == RUN) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_sum   <= {fa_sum, r_sum[WIDTH-1:1]};
      r_carry <= fa_cout;
      if (w_last) begin
        r_cnt  <= '0;
        r_cout <= fa_cout;
        r_ovf  <= r_carry ^ fa_cout;
      end else begin
        r_cnt  <= r_cnt + CW'(1);
      end
    end
  end

  assign sum       = r_sum;
  assign carry_out = r_cout;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl: behavioural full adder, arithmetic reference
// model, directed corner cases, randomized operations, and reset scenarios.
module tb_serial_add_ctrl;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         carry_in;
  logic         sub;
  logic         fa_a;
  logic         fa_b;
  logic         fa_cin;
  logic         fa_sum;
  logic         fa_cout;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_out;
  logic         overflow;

  int n_tests = 0;
  int n_fail  = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .carry_in  (carry_in),
    .sub       (sub),
    .fa_a      (fa_a),
    .fa_b      (fa_b),
    .fa_cin    (fa_cin),
    .fa_sum    (fa_sum),
    .fa_cout   (fa_cout),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  // External combinational full adder.
  assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
  assign fa_cout = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain integer arithmetic on the operands.
  task automatic ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic sb,
                           output logic [W-1:0] s, output logic co, output logic ov);
    int          sa;
    int          sbv;
    int          r;
    int unsigned u;
    sa  = int'($signed(a));
    sbv = int'($signed(b));
    if (sb) begin
      r  = sa - sbv;
      co = (a >= b);
      u  = (int'(a) - int'(b)) & ((1 << W) - 1);
    end else begin
      r  = sa + sbv + int'(cin);
      u  = int'(a) + int'(b) + int'(cin);
      co = (u >= (1 << W));
    end
    s  = u[W-1:0];
    ov = (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1)));
  endtask

  // Runs one operation from start through one cycle past done and reports
  // observations; disturb=1 pokes start/operands during RUN.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cin, input logic sb, input bit disturb,
                       output logic [W-1:0] s, output logic co, output logic ov,
                       output int done_k, output int done_cnt, output int busy_cnt,
                       output int fa_err, output logic [W-1:0] s_hold);
    logic [W-1:0] bop;
    int unsigned  mask;
    int unsigned  c0;
    logic         exp_a;
    logic         exp_b;
    logic         exp_c;
    s = '0; co = 1'b0; ov = 1'b0; s_hold = '0;
    done_k = -1; done_cnt = 0; busy_cnt = 0; fa_err = 0;
    bop = sb ? ~b : b;
    c0  = sb ? 1 : int'(cin);
    @(negedge clk);
    op_a = a; op_b = b; carry_in = cin; sub = sb; start = 1'b1;
    for (int k = 0; k <= W + 1; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_k < 0) done_k = k;
        s = sum; co = carry_out; ov = overflow;
      end
      if (k < W) begin
        mask  = (1 << k) - 1;
        exp_a = a[k];
        exp_b = bop[k];
        exp_c = (((int'(a) & mask) + (int'(bop) & mask) + c0) >> k) & 1;
      end else begin
        exp_a = 1'b0; exp_b = 1'b0; exp_c = 1'b0;
      end
      if (fa_a !== exp_a || fa_b !== exp_b || fa_cin !== exp_c) fa_err++;
      if (k == W + 1) s_hold = sum;
      if (disturb && k == 2) begin
        start = 1'b1; op_a = ~a; op_b = W'($urandom); sub = ~sb; carry_in = ~cin;
      end
      if (disturb && k == 3) start = 1'b0;
    end
  endtask

  task automatic test_reset;
    #3;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_status: busy=%b done=%b, required 0 0", busy, done);
    end
    n_tests++;
    if (sum !== '0 || carry_out !== 1'b0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL reset_result: sum=%h co=%b ov=%b, required 00 0 0", sum, carry_out, overflow);
    end
    n_tests++;
    if ({fa_a, fa_b, fa_cin} !== 3'b000) begin
      n_fail++; $display("FAIL reset_fa: fa=%b, required 000", {fa_a, fa_b, fa_cin});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_directed;
    logic [W-1:0] ta [6];
    logic [W-1:0] tb [6];
    logic         tc [6];
    logic         tsb[6];
    logic [W-1:0] es [6];
    logic         eco[6];
    logic         eov[6];
    logic [W-1:0] s;
    logic [W-1:0] sh;
    logic         co;
    logic         ov;
    int           dk, dc, bc, fe;
    ta[0]=8'h0F; tb[0]=8'h01; tc[0]=0; tsb[0]=0; es[0]=8'h10; eco[0]=0; eov[0]=0;
    ta[1]=8'hFF; tb[1]=8'h01; tc[1]=0; tsb[1]=0; es[1]=8'h00; eco[1]=1; eov[1]=0;
    ta[2]=8'h7F; tb[2]=8'h01; tc[2]=0; tsb[2]=0; es[2]=8'h80; eco[2]=0; eov[2]=1;
    ta[3]=8'h00; tb[3]=8'h00; tc[3]=1; tsb[3]=0; es[3]=8'h01; eco[3]=0; eov[3]=0;
    ta[4]=8'h05; tb[4]=8'h07; tc[4]=0; tsb[4]=1; es[4]=8'hFE; eco[4]=0; eov[4]=0;
    ta[5]=8'h80; tb[5]=8'h01; tc[5]=1; tsb[5]=1; es[5]=8'h7F; eco[5]=1; eov[5]=1;
    for (int i = 0; i < 6; i++) begin
      do_op(ta[i], tb[i], tc[i], tsb[i], 1'b0, s, co, ov, dk, dc, bc, fe, sh);
      n_tests++;
      if (s !== es[i] || co !== eco[i] || ov !== eov[i]) begin
        n_fail++;
        $display("FAIL directed_%0d: sum=%h co=%b ov=%b, required %h %b %b", i, s, co, ov, es[i], eco[i], eov[i]);
      end
      n_tests++;
      if (dk != W || dc != 1 || bc != W) begin
        n_fail++;
        $display("FAIL directed_timing_%0d: done_at=%0d done_cycles=%0d busy_cycles=%0d, required %0d 1 %0d", i, dk, dc, bc, W, W);
      end
      n_tests++;
      if (fe != 0 || sh !== es[i]) begin
        n_fail++;
        $display("FAIL directed_fa_hold_%0d: fa_errors=%0d held_sum=%h, required 0 %h", i, fe, sh, es[i]);
      end
    end
  endtask

  task automatic test_random;
    logic [W-1:0] a, b, s, sh, es;
    logic         cin, sb, co, ov, eco, eov;
    int           dk, dc, bc, fe;
    for (int i = 0; i < 24; i++) begin
      a   = W'($urandom);
      b   = W'($urandom);
      cin = 1'($urandom);
      sb  = 1'($urandom);
      ref_model(a, b, cin, sb, es, eco, eov);
      do_op(a, b, cin, sb, 1'b0, s, co, ov, dk, dc, bc, fe, sh);
      n_tests++;
      if (s !== es || co !== eco || ov !== eov || dk != W || fe != 0) begin
        n_fail++;
        $display("FAIL random_%0d a=%h b=%h cin=%b sub=%b: sum=%h co=%b ov=%b done_at=%0d fa_err=%0d, required %h %b %b %0d 0",
                 i, a, b, cin, sb, s, co, ov, dk, fe, es, eco, eov, W);
      end
    end
  endtask

  task automatic test_ignore_start;
    logic [W-1:0] s, sh, es;
    logic         co, ov, eco, eov;
    int           dk, dc, bc, fe;
    ref_model(8'h3C, 8'h55, 1'b0, 1'b0, es, eco, eov);
    do_op(8'h3C, 8'h55, 1'b0, 1'b0, 1'b1, s, co, ov, dk, dc, bc, fe, sh);
    n_tests++;
    if (s !== es || co !== eco || ov !== eov) begin
      n_fail++;
      $display("FAIL ignore_start_result: sum=%h co=%b ov=%b, required %h %b %b", s, co, ov, es, eco, eov);
    end
    n_tests++;
    if (dk != W || dc != 1 || bc != W || fe != 0) begin
      n_fail++;
      $display("FAIL ignore_start_timing: done_at=%0d done_cycles=%0d busy_cycles=%0d fa_err=%0d, required %0d 1 %0d 0", dk, dc, bc, fe, W, W);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [W-1:0] s, sh, es;
    logic         co, ov, eco, eov;
    int           dk, dc, bc, fe;
    int           spurious;
    spurious = 0;
    @(negedge clk);
    op_a = 8'hB7; op_b = 8'h6E; carry_in = 1'b1; sub = 1'b0; start = 1'b1;
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0) begin
      n_fail++; $display("FAIL midrun_reset: busy=%b done=%b sum=%h, required 0 0 00", busy, done, sum);
    end
    n_tests++;
    if ({fa_a, fa_b, fa_cin} !== 3'b000 || carry_out !== 1'b0 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL midrun_reset_aux: fa=%b co=%b ov=%b, required 000 0 0", {fa_a, fa_b, fa_cin}, carry_out, overflow);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (done) spurious++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      if (done || busy) spurious++;
    end
    n_tests++;
    if (spurious != 0) begin
      n_fail++; $display("FAIL midrun_no_done: activity_cycles=%0d, required 0", spurious);
    end
    ref_model(8'h5A, 8'hC3, 1'b0, 1'b1, es, eco, eov);
    do_op(8'h5A, 8'hC3, 1'b0, 1'b1, 1'b0, s, co, ov, dk, dc, bc, fe, sh);
    n_tests++;
    if (s !== es || co !== eco || ov !== eov || dk != W || dc != 1) begin
      n_fail++;
      $display("FAIL after_reset_op: sum=%h co=%b ov=%b done_at=%0d done_cycles=%0d, required %h %b %b %0d 1", s, co, ov, dk, dc, es, eco, eov, W);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; carry_in = 1'b0; sub = 1'b0;
    test_reset;
    test_directed;
    test_ignore_start;
    test_random;
    test_reset_mid_run;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width in bits (>=2).
REQ-002 SHALL have port: clk  input  1  rising-edge system clock.
REQ-003 SHALL have port: rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 SHALL have port: start  input  1  request to begin an operation.
REQ-005 SHALL have port: op_a  input  WIDTH  operand A.
REQ-006 SHALL have port: op_b  input  WIDTH  operand B.
REQ-007 SHALL have port: carry_in  input  1  initial carry for add.
REQ-008 SHALL have port: sub  input  1  1 = compute A-B, 0 = A+B+carry_in.
REQ-009 SHALL have port: fa_a  output  1  A bit driven to the external 1-bit full adder.
REQ-010 SHALL have port: fa_b  output  1  B bit (inverted when subtracting) to the full adder.
REQ-011 SHALL have port: fa_cin  output  1  carry driven to the full adder.
REQ-012 SHALL have port: fa_sum  input  1  sum bit returned by the full adder (combinational).
REQ-013 SHALL have port: fa_cout  input  1  carry out returned by the full adder (combinational).
REQ-014 SHALL have port: busy  output  1  operation in progress.
REQ-015 SHALL have port: done  output  1  one-cycle completion pulse.
REQ-016 SHALL have port: sum  output  WIDTH  registered result.
REQ-017 SHALL have port: carry_out  output  1  final carry (add: carry; sub: 1 = no borrow).
REQ-018 SHALL have port: overflow  output  1  two's-complement overflow of the result.

Function
REQ-019 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start=1 at a rising edge; RUN->DONE after WIDTH RUN cycles; DONE->IDLE unconditionally after one cycle.
REQ-020 SHALL accept start only in IDLE; start in RUN or DONE is ignored, not queued.
REQ-021 SHALL latch op_a, op_b, sub at the accepting edge; later input changes have no effect on the running operation.
REQ-022 SHALL set the initial carry register to 1 when sub=1, else to carry_in, at the accepting edge.
REQ-023 SHALL in RUN cycle i (i=0..WIDTH-1, LSB first) drive fa_a=A[i], fa_b=B[i]^sub, fa_cin=carry register, combinationally from registered state.
REQ-024 SHALL at each RUN edge store fa_sum into result bit i and fa_cout into the carry register.
REQ-025 SHALL at the final RUN edge (i=WIDTH-1) set overflow = carry register ^ fa_cout and carry_out = fa_cout.
REQ-026 SHALL drive fa_a, fa_b, fa_cin to 0 outside RUN.
REQ-027 SHALL assert busy exactly in RUN; done exactly in DONE (one cycle).
REQ-028 SHALL present final sum/carry_out/overflow when done=1 and hold them until the next accepted start.
REQ-029 SHALL clear sum, carry_out, overflow to 0 at an accepting edge.
REQ-030 SHALL give latency: start accepted at edge E0; done high from edge E(WIDTH) to E(WIDTH+1); next start accepted no earlier than E(WIDTH+1).
REQ-031 SHALL use an internal bit counter wide enough for WIDTH-1 with no wrap into a spurious extra RUN cycle.

Reset
REQ-032 SHALL on rst_n=0, immediately and regardless of clk, enter IDLE and clear busy, done, sum, carry_out, overflow, fa_a, fa_b, fa_cin, counter, and all latched state to 0.
REQ-033 SHALL, when reset asserts mid-RUN, abandon the operation with no done pulse; a new start after release is handled normally.

Verification
REQ-034 SHALL cover (WIDTH=8) 8'h0F+8'h01, carry_in=0 -> sum=8'h10, carry_out=0, overflow=0, done high E8..E9 only.
REQ-035 SHALL cover 8'hFF+8'h01, carry_in=0 -> sum=8'h00, carry_out=1, overflow=0.
REQ-036 SHALL cover 8'h7F+8'h01 -> sum=8'h80, carry_out=0, overflow=1; and 8'h00+8'h00, carry_in=1 -> sum=8'h01.
REQ-037 SHALL cover sub=1, 8'h05-8'h07 -> sum=8'hFE, carry_out=0, overflow=0; and 8'h80-8'h01 -> sum=8'h7F, overflow=1.
REQ-038 SHALL cover start pulsed again and op_a changed during RUN -> ignored, result matches the originally latched operands.
REQ-039 SHALL cover rst_n low at RUN cycle 3 -> busy=0 and sum=0 immediately, no done pulse, next operation correct.
